motoro3_commutation_sequencer: RTL and testbench

Six-step commutation controller for the 3-phase motor drive. It sequences the phase enables, generates the step period counter with its last-cycle pulse, and produces the PWM duty word consumed by the motor PWM generator. On start it aligns the rotor, then ramps speed and duty to the requested values. On stop it coasts the bridge off before returning to idle.

---
 rtl/motoro3_commutation_sequencer.sv | 124 ++++++++++++
 tb/tb_motoro3_commutation_sequencer.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/motoro3_commutation_sequencer.sv
// motoro3_commutation_sequencer: six-step BLDC commutation with align, ramp, run and coast phases
module motoro3_commutation_sequencer #(
  parameter logic [24:0] ALIGN_CYCLES = 25'd5000000,
  parameter logic [24:0] START_PERIOD = 25'd2000000,
  parameter logic [24:0] PERIOD_DEC   = 25'd20000,
  parameter logic [24:0] MIN_PERIOD   = 25'd16,
  parameter logic [11:0] DUTY_START   = 12'h110,
  parameter logic [11:0] DUTY_STEP    = 12'h020,
  parameter logic [24:0] COAST_CYCLES = 25'd100000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        stop,
  input  logic [24:0] targetPeriod,
  input  logic [11:0] runDuty,
  output logic        aE,
  output logic        bE,
  output logic        cE,
  output logic        aP,
  output logic        bP,
  output logic        cP,
  output logic [24:0] m3cnt,
  output logic        m3cntLast1,
  output logic [11:0] pwmDuty,
  output logic [2:0]  step,
  output logic [2:0]  state
);
  typedef enum logic [2:0] {IDLE = 3'd0, ALIGN = 3'd1, RAMP = 3'd2, RUN = 3'd3, COAST = 3'd4} state_t;
  state_t st, st_n;
  logic [24:0] cnt_n, per, per_n, tgt, dec_per;
  logic [25:0] diff;
  logic [12:0] dsum;
  logic [11:0] duty_n, ramp_duty;
  logic [2:0] stp_n, stp_inc;
  logic last_n, on;
  logic [5:0] ph, ph_n;
  assign {aE, bE, cE, aP, bP, cP} = ph;
  assign state = st;
  always_comb begin
    tgt = targetPeriod < MIN_PERIOD ? MIN_PERIOD : targetPeriod;
    diff = {1'b0, per} - {1'b0, PERIOD_DEC};
    dec_per = (diff[25] || diff[24:0] < tgt) ? tgt : diff[24:0];
    dsum = {1'b0, pwmDuty} + {1'b0, DUTY_STEP};
    ramp_duty = dsum > {1'b0, runDuty} ? runDuty : dsum[11:0];
    stp_inc = step == 3'd5 ? 3'd0 : step + 3'd1;
    st_n = st;
    cnt_n = m3cnt - 25'd1;
    per_n = per;
    duty_n = pwmDuty;
    stp_n = step;
    case (st)
      IDLE: begin
        cnt_n = '0;
        if (start && !stop) begin
          st_n = ALIGN;
          cnt_n = ALIGN_CYCLES - 25'd1;
          duty_n = DUTY_START;
          stp_n = '0;
        end
      end
      ALIGN: if (m3cnt == '0) begin
        st_n = RAMP;
        per_n = START_PERIOD;
        cnt_n = START_PERIOD - 25'd1;
      end
      RAMP: if (m3cnt == '0) begin
        stp_n = stp_inc;
        per_n = dec_per;
        duty_n = ramp_duty;
        cnt_n = dec_per - 25'd1;
        if (dec_per == tgt && ramp_duty == runDuty) st_n = RUN;
      end
      RUN: if (m3cnt == '0) begin
        stp_n = stp_inc;
        per_n = tgt;
        duty_n = runDuty;
        cnt_n = tgt - 25'd1;
      end
      COAST: if (m3cnt == '0) begin
        st_n = IDLE;
        cnt_n = '0;
      end
      default: begin
        st_n = IDLE;
        cnt_n = '0;
      end
    endcase
    // stop beats a simultaneous step boundary or start
    if (stop && (st == ALIGN || st == RAMP || st == RUN)) begin
      st_n = COAST;
      cnt_n = COAST_CYCLES - 25'd1;
      duty_n = '0;
      stp_n = '0;
    end
    on = st_n == ALIGN || st_n == RAMP || st_n == RUN;
    last_n = (st_n == RAMP || st_n == RUN) && cnt_n == '0;
    ph_n = !on ? 6'b000_000 :
           stp_n == 3'd0 ? 6'b110_100 :
           stp_n == 3'd1 ? 6'b101_100 :
           stp_n == 3'd2 ? 6'b011_010 :
           stp_n == 3'd3 ? 6'b110_010 :
           stp_n == 3'd4 ? 6'b101_001 : 6'b011_001;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      st <= IDLE;
      m3cnt <= '0;
      m3cntLast1 <= 1'b0;
      per <= '0;
      pwmDuty <= '0;
      step <= '0;
      ph <= '0;
    end else begin
      st <= st_n;
      m3cnt <= cnt_n;
      m3cntLast1 <= last_n;
      per <= per_n;
      pwmDuty <= duty_n;
      step <= stp_n;
      ph <= ph_n;
    end
  end
endmodule

// File: tb/tb_motoro3_commutation_sequencer.sv
// tb_motoro3_commutation_sequencer: directed checks of align, ramp, run, commutation order, coast and reset
module tb_motoro3_commutation_sequencer;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0, stop = 1'b0;
  logic [24:0] targetPeriod = 25'd500;
  logic [11:0] runDuty = 12'h150;
  logic aE, bE, cE, aP, bP, cP, m3cntLast1;
  logic [24:0] m3cnt;
  logic [11:0] pwmDuty;
  logic [2:0] step, state;
  int total = 0, bad = 0;
  always #50 clk = ~clk;
  motoro3_commutation_sequencer #(
    .ALIGN_CYCLES(25'd100), .START_PERIOD(25'd1000), .PERIOD_DEC(25'd100), .MIN_PERIOD(25'd16),
    .DUTY_START(12'h110), .DUTY_STEP(12'h020), .COAST_CYCLES(25'd50)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .targetPeriod(targetPeriod), .runDuty(runDuty),
    .aE(aE), .bE(bE), .cE(cE), .aP(aP), .bP(bP), .cP(cP), .m3cnt(m3cnt), .m3cntLast1(m3cntLast1),
    .pwmDuty(pwmDuty), .step(step), .state(state)
  );
  function automatic logic [49:0] outs();
    return {aE, bE, cE, aP, bP, cP, m3cntLast1, pwmDuty, step, state, m3cnt};
  endfunction
  function automatic logic [5:0] ph();
    return {aE, bE, cE, aP, bP, cP};
  endfunction
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic measure(output int len);
    len = 1;
    while (!m3cntLast1 && len < 3000) begin
      tick();
      len++;
    end
    tick();
  endtask
  int len, n, es;
  int lens[7] = '{1000, 900, 800, 700, 600, 500, 500};
  logic [11:0] duties[7] = '{12'h130, 12'h150, 12'h150, 12'h150, 12'h150, 12'h150, 12'h150};
  logic [2:0] states[7] = '{3'd2, 3'd2, 3'd2, 3'd2, 3'd3, 3'd3, 3'd3};
  logic [5:0] pat[6] = '{6'b110_100, 6'b101_100, 6'b011_010, 6'b110_010, 6'b101_001, 6'b011_001};
  initial begin
    start = 1'b1;
    repeat (3) tick();
    chk("reset_outs", outs(), 0);
    rst = 1'b0;
    start = 1'b0;
    tick();
    chk("idle_hold", outs(), 0);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("align_entry", {ph(), pwmDuty, state, m3cnt}, {6'b110_100, 12'h110, 3'd1, 25'd99});
    repeat (99) tick();
    chk("align_last", {state, m3cnt, m3cntLast1, ph()}, {3'd1, 25'd0, 1'b0, 6'b110_100});
    tick();
    chk("ramp_entry", {state, step, m3cnt, pwmDuty}, {3'd2, 3'd0, 25'd999, 12'h110});
    for (int i = 0; i < 7; i++) begin
      measure(len);
      chk($sformatf("ramp_len%0d", i), len, lens[i]);
      chk($sformatf("ramp_after%0d", i), {state, pwmDuty, step}, {states[i], duties[i], 3'((i + 1) % 6)});
    end
    targetPeriod = 25'd20;
    measure(len);
    chk("run_len_before_tgt", len, 500);
    es = 2;
    for (int i = 0; i < 7; i++) begin
      chk($sformatf("comm_step%0d", i), {step, ph()}, {3'(es), pat[es]});
      measure(len);
      chk($sformatf("comm_len%0d", i), len, 20);
      es = (es + 1) % 6;
    end
    start = 1'b1;
    stop = 1'b1;
    tick();
    start = 1'b0;
    stop = 1'b0;
    chk("startstop_coast", {state, ph(), pwmDuty, step, m3cntLast1, m3cnt}, {3'd4, 6'd0, 12'd0, 3'd0, 1'b0, 25'd49});
    repeat (50) tick();
    chk("coast_to_idle", outs(), 0);
    start = 1'b1;
    tick();
    start = 1'b0;
    n = 0;
    while (!(state == 3'd2 && m3cnt == 25'd37) && n < 3000) begin
      tick();
      n++;
    end
    chk("reach_ramp37", {state, m3cnt, step}, {3'd2, 25'd37, 3'd0});
    stop = 1'b1;
    tick();
    stop = 1'b0;
    chk("stop_ramp", {state, ph(), pwmDuty, m3cntLast1, m3cnt}, {3'd4, 6'd0, 12'd0, 1'b0, 25'd49});
    for (int i = 1; i <= 49; i++) begin
      start = (i == 10);
      tick();
    end
    start = 1'b0;
    chk("coast_last", {state, m3cnt}, {3'd4, 25'd0});
    tick();
    chk("coast_idle", outs(), 0);
    targetPeriod = 25'd5;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (100) tick();
    len = 0;
    n = 0;
    while (len != 16 && n < 20) begin
      measure(len);
      n++;
    end
    chk("clamp_settle", {state, pwmDuty, m3cnt}, {3'd3, 12'h150, 25'd15});
    measure(len);
    chk("clamp_len", len, 16);
    repeat (5) tick();
    runDuty = 12'h080;
    tick();
    chk("duty_deferred", {pwmDuty, m3cnt}, {12'h150, 25'd9});
    n = 0;
    while (!m3cntLast1 && n < 40) begin
      tick();
      n++;
    end
    chk("duty_at_last", {pwmDuty, m3cntLast1}, {12'h150, 1'b1});
    tick();
    chk("duty_applied", {pwmDuty, m3cnt, state}, {12'h080, 25'd15, 3'd3});
    repeat (4) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_mid_run", outs(), 0);
    repeat (5) tick();
    chk("idle_after_rst", outs(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
